// File: rtl/multiplicador_sequencial.sv
// Iterative shift-add multiplier for the ULA datapath.
// Takes A/B/sgn on a start strobe, converts signed operands to magnitudes,
// then examines one multiplier bit per RUN cycle and adds the multiplicand
// into the upper half of a 2*WIDTH+1-bit accumulator before shifting it right.
// The sign is applied once in FIX. RES is registered and is updated only on
// the cycle before the one-cycle done pulse.
module multiplicador_sequencial #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   RES
);

  // State encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The bit counter runs 0..WIDTH-1, so $clog2(WIDTH) bits are enough for WIDTH >= 2.
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

  logic [2:0]         state;
  logic [2:0]         state_next;

  // Operands captured on the accepting edge; later changes on A/B/sgn are ignored.
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               sgn_reg;

  // Working registers for the shift-add loop.
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [2*WIDTH-1:0] res;

  logic               accept;
  logic [WIDTH:0]     add_val;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_shift;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1),
  // which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  // A new operation is only taken while no operation is in flight.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);
  assign RES  = res;

  // One shift-add step: add the multiplicand into the upper half if the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    add_val   = '0;
    if (mplier[0]) add_val = {1'b0, mcand};
    sum       = acc[2*WIDTH:WIDTH] + add_val;
    acc_shift = {1'b0, sum, acc[WIDTH-1:1]};
  end

  // Next-state logic for the IDLE/LOAD/RUN/FIX/DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_LOAD;
      S_LOAD:  state_next = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = accept ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Operand capture on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      sgn_reg <= sgn;
    end
  end

  // Datapath: magnitude load, shift-add iterations and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          mcand  <= magnitude(a_reg, sgn_reg);
          mplier <= magnitude(b_reg, sgn_reg);
          neg    <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        S_RUN: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result register: apply the sign once, then hold until the next FIX.
  // A zero magnitude negates to zero, so no special case is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (state == S_FIX) begin
      res <= neg ? (~acc[2*WIDTH-1:0] + ONE_2W) : acc[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Testbench for multiplicador_sequencial (WIDTH=8).
// Stimulus pushes hand-computed products plus the cycle at which done must
// appear into a scoreboard queue; an independent monitor pops on every done.
module tb_multiplicador_sequencial;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] res;

  typedef struct {
    logic [2*W-1:0] res;
    int             due;
    int             id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   op_id = 0;

  multiplicador_sequencial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .RES   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done got=RES %h exp=no done at cycle %0d", res, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("res[%0d]", e.id), 32'(res), 32'(e.res));
        check($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.due));
        check($sformatf("busy_in_done[%0d]", e.id), 32'(busy), 32'd0);
      end
    end
  end

  // Issue one operation. Entered and left just after a falling edge.
  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] exp_res, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wait_idle", 32'(busy), 32'd0);
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    op_id++;
    if (push) begin
      e.res = exp_res;
      e.due = cyc + W + 2;
      e.id  = op_id;
      sb.push_back(e);
    end
    check($sformatf("busy_after_start[%0d]", op_id), 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    sgn   = ~s;
    a     = ~x;
    b     = x ^ y;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) check("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  // Directed vectors: sgn, A, B, hand-computed product.
  typedef struct {
    logic           s;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b1, 8'h03, 8'hFB, 16'hFFF1},   //  3 * -5   = -15
    '{1'b1, 8'h80, 8'h80, 16'h4000},   // -128*-128 = 16384
    '{1'b1, 8'h80, 8'h01, 16'hFF80},   // -128 * 1
    '{1'b0, 8'hFF, 8'hFF, 16'hFE01},   // 255 * 255
    '{1'b1, 8'hFF, 8'hFF, 16'h0001},   // -1 * -1
    '{1'b1, 8'h00, 8'hFF, 16'h0000},   // 0 * -1 (neg set, still zero)
    '{1'b0, 8'h00, 8'hFF, 16'h0000},   // 0 * 255
    '{1'b1, 8'h7F, 8'h7F, 16'h3F01},   // 127 * 127
    '{1'b1, 8'h7F, 8'h80, 16'hC080},   // 127 * -128 = -16256
    '{1'b0, 8'h80, 8'h80, 16'h4000},   // 128 * 128
    '{1'b0, 8'h01, 8'hFF, 16'h00FF},   // 1 * 255
    '{1'b1, 8'h01, 8'hFF, 16'hFFFF},   // 1 * -1
    '{1'b1, 8'hFF, 8'h01, 16'hFFFF},   // -1 * 1
    '{1'b0, 8'h7F, 8'h80, 16'h3F80},   // 127 * 128
    '{1'b1, 8'h0C, 8'hF6, 16'hFF88},   // 12 * -10 = -120
    '{1'b0, 8'h0C, 8'hF6, 16'h0B88},   // 12 * 246 = 2952
    '{1'b1, 8'hF6, 8'hF6, 16'h0064}    // -10 * -10 = 100
  };

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_res",  32'(res),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; successive calls start in the DONE cycle (back-to-back),
    // with an idle gap inserted every third op to exercise the IDLE path too.
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].p, 1'b1);
      if (i % 3 == 2) begin
        drain();
        repeat (2) @(negedge clk);
      end
    end
    drain();
    @(negedge clk);

    // start while busy with different operands must be ignored.
    do_op(1'b1, 8'h05, 8'h07, 16'h0023, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("res_hold", 32'(res), 32'h0023);

    // Reset in the middle of RUN aborts with no done pulse.
    do_op(1'b0, 8'h11, 8'h22, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res",  32'(res),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_res", 32'(res), 32'd0);

    // Fresh operation after release.
    do_op(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1);
    do_op(1'b0, 8'hAA, 8'h03, 16'h01FE, 1'b1);
    drain();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
